monument_input_ctrl: RTL
========================

# monument_input_ctrl

Input front end for the Monument Valley game. Conditions the raw DE1 pushbuttons and direction switches into the `move`, `dir` and `activate` signals consumed by the `MonumentValley` top level, directly upstream of it. Provides synchronization, per-key debouncing, a fixed-length `move` window during which `dir` is frozen, and auto-repeat while the move key is held.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a key level change (10 ms at 50 MHz); minimum 1.
- `MOVE_HOLD`, default 65536: exact length in cycles of each `move` high window; minimum 1.
- `GAP_CYCLES`, default 16: forced `move`-low cycles after each window; minimum 1.
- `REPEAT_CYCLES`, default 12500000: wait in cycles before auto-repeating a held move key; minimum 1.
- `clock` in 1: single system clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `key_move_n` in 1: raw move pushbutton, active-low, asynchronous.
- `key_act_n` in 1: raw activate pushbutton, active-low, asynchronous.
- `dir_sw` in 3: raw direction switches, asynchronous.
- `move` out 1: registered; high for exactly `MOVE_HOLD` cycles per accepted move.
- `dir` out 3: registered latched direction; constant whenever `move` is high.
- `activate` out 1: registered one-cycle pulse per accepted activate press.

## Operation
- Synchronization: two flip-flop stages on `key_move_n`, `key_act_n` and each `dir_sw` bit. The sync flops for keys reset to 1 (released); the `dir_sw` sync flops reset to 0.
- Debounce, independent per key: a counter increments while the synchronized level differs from the debounced state and clears on any cycle where they match. When the counter reaches `DEBOUNCE_CYCLES`, the debounced state flips and the counter clears. A press is a debounced released→pressed transition.
- `activate`: high for exactly one cycle after each activate press. It is independent of the move FSM and never suppressed.
- Move FSM, 2-bit state:
  - IDLE: `move`=0. On a move press, latch synchronized `dir_sw` into `dir` and go to HOLD.
  - HOLD: `move`=1 for exactly `MOVE_HOLD` cycles, then go to GAP.
  - GAP: `move`=0 for `GAP_CYCLES` cycles. At expiry, go to REPEAT if the debounced move key is still pressed, otherwise go to IDLE.
  - REPEAT: `move`=0. If the debounced key is released, go to IDLE immediately. After `REPEAT_CYCLES` cycles, latch `dir` from synchronized `dir_sw` and go to HOLD.
- Presses arriving in HOLD, GAP or REPEAT are discarded. There is no queuing.
- `dir` changes only on the latch events above. `dir_sw` activity at all other times has no effect on `dir`.
- Counters are sized with `$clog2` of their parameter plus 1 bit and never wrap. Each counter is cleared on every state entry.

## Timing
- Reset (asynchronous, immediate): `move`=0, `dir`=0, `activate`=0, FSM=IDLE, debounced states=released, all counters=0. Reset asserted mid-HOLD drops `move` without waiting for a clock edge. After reset deasserts, a key already held low is accepted as a fresh press after the normal latency.
- Press latency: if `key_move_n` goes low and stays low from before edge 0, then:
  - the synchronized level is low at edge 2;
  - the debounced state flips at edge 2+`DEBOUNCE_CYCLES`;
  - `move` and the new `dir` are visible after edge 3+`DEBOUNCE_CYCLES`.
- `activate` uses the same latency and is high for one cycle only.
- Release latency follows the same path: 2 + `DEBOUNCE_CYCLES` cycles to the debounced released state.
- Glitch rejection: a raw level change shorter than `DEBOUNCE_CYCLES` synchronized cycles produces no debounced transition.
- Repeat period while held: `MOVE_HOLD` + `GAP_CYCLES` + `REPEAT_CYCLES` cycles, rising edge to rising edge of `move`.
- Simultaneous move and activate presses are both honoured in the same cycle.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `MOVE_HOLD`=8, `GAP_CYCLES`=2, `REPEAT_CYCLES`=20.
- Reset, then idle inputs for 100 cycles -> `move`, `dir` and `activate` are 0 throughout.
- Set `dir_sw`=3'b101, then press `key_move_n` low for 10 cycles -> `move` rises 7 cycles after the press and stays high for exactly 8 cycles with `dir`=3'b101. Exactly one window occurs.
- Hold `key_move_n` low for 80 cycles and change `dir_sw` from 3'b001 to 3'b010 mid-HOLD -> the first window carries `dir`=1 and does not change. A second window starts 30 cycles after the first rise with `dir`=2.
- Apply a 3-cycle low glitch on `key_act_n` and then a 10-cycle press -> the glitch produces no pulse. The press produces exactly one `activate` pulse, 7 cycles after its start.
- Issue a second move press during HOLD and a simultaneous activate press -> the second move press is ignored and `activate` pulses once.
- Assert `reset` at cycle 3 of HOLD -> `move` goes low immediately. After deassertion with the key still held, a new window begins 7 cycles later.

Source files
------------

// File: rtl/monument_input_ctrl.sv
// ---------------------------------------------------------------------------
// monument_input_ctrl
//
// Input front end for the Monument Valley game. Takes the raw DE1 move and
// activate pushbuttons (active-low) and the three direction switches, and
// produces the conditioned move / dir / activate signals for the game top
// level.
//
// Processing chain:
//   raw pins -> 2-flop synchronizers -> per-key debounce -> press detect
//   move press  -> move FSM (fixed-length move window, gap, auto-repeat)
//   act press   -> one-cycle activate pulse
//
// Move FSM states:
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | move low, waiting for a debounced move press
//   HOLD   | move high for exactly MOVE_HOLD cycles, dir frozen
//   GAP    | move forced low for GAP_CYCLES cycles
//   REPEAT | key still held; wait REPEAT_CYCLES, then start a new window
//
// Parameters:
//   DEBOUNCE_CYCLES  stable synchronized cycles needed to accept a key change
//   MOVE_HOLD        length of each move window in cycles
//   GAP_CYCLES       forced move-low cycles after each window
//   REPEAT_CYCLES    wait before auto-repeating a held move key
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   key_move_n  in   raw move pushbutton, active-low, asynchronous
//   key_act_n   in   raw activate pushbutton, active-low, asynchronous
//   dir_sw      in   raw direction switches [2:0], asynchronous
//   move        out  registered move window
//   dir         out  registered direction, latched at each window start
//   activate    out  registered one-cycle pulse per activate press
// ---------------------------------------------------------------------------
module monument_input_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned MOVE_HOLD       = 65536,
    parameter int unsigned GAP_CYCLES      = 16,
    parameter int unsigned REPEAT_CYCLES   = 12500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_move_n,
    input  logic       key_act_n,
    input  logic [2:0] dir_sw,
    output logic       move,
    output logic [2:0] dir,
    output logic       activate
);

    // -----------------------------------------------------------------------
    // Counter sizing. The FSM timer is shared by HOLD, GAP and REPEAT, so it
    // is sized for the largest of the three intervals.
    // -----------------------------------------------------------------------
    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES) + 1;

    localparam int unsigned T_MAX_HG = (MOVE_HOLD > GAP_CYCLES) ? MOVE_HOLD : GAP_CYCLES;
    localparam int unsigned T_MAX    = (T_MAX_HG > REPEAT_CYCLES) ? T_MAX_HG : REPEAT_CYCLES;
    localparam int unsigned T_W      = $clog2(T_MAX) + 1;

    localparam logic [DB_W-1:0] DB_LIMIT    = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [T_W-1:0]  HOLD_LAST   = T_W'(MOVE_HOLD - 1);
    localparam logic [T_W-1:0]  GAP_LAST    = T_W'(GAP_CYCLES - 1);
    localparam logic [T_W-1:0]  REPEAT_LAST = T_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        GAP    = 2'd2,
        REPEAT = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // Synchronizers. Key bit 0 is move, bit 1 is activate. Keys reset to the
    // released level (1) so a key held through reset is seen as a fresh
    // press once reset is removed.
    // -----------------------------------------------------------------------
    logic [1:0] key_s1;
    logic [1:0] key_s2;
    logic [2:0] dir_s1;
    logic [2:0] dir_s2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_s1 <= 2'b11;
            key_s2 <= 2'b11;
            dir_s1 <= 3'b000;
            dir_s2 <= 3'b000;
        end else begin
            key_s1 <= {key_act_n, key_move_n};
            key_s2 <= key_s1;
            dir_s1 <= dir_sw;
            dir_s2 <= dir_s1;
        end
    end

    // -----------------------------------------------------------------------
    // Debounce. The counter runs while the synchronized level disagrees with
    // the accepted level and clears the moment they agree, so any glitch
    // shorter than the limit leaves no trace. key_db_d is the accepted level
    // one cycle late, used for edge detection.
    // -----------------------------------------------------------------------
    logic [1:0]      key_db;
    logic [1:0]      key_db_d;
    logic [DB_W-1:0] db_cnt [2];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_db   <= 2'b11;
            key_db_d <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            key_db_d <= key_db;
            for (int i = 0; i < 2; i++) begin
                if (key_s2[i] == key_db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LIMIT) begin
                    key_db[i] <= key_s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // A press is an accepted released(1) -> pressed(0) transition.
    logic [1:0] key_press;
    logic       move_press;
    logic       act_press;
    logic       move_held;

    assign key_press  = key_db_d & ~key_db;
    assign move_press = key_press[0];
    assign act_press  = key_press[1];
    assign move_held  = ~key_db[0];

    // -----------------------------------------------------------------------
    // Activate pulse: independent of the move FSM.
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            activate <= 1'b0;
        end else begin
            activate <= act_press;
        end
    end

    // -----------------------------------------------------------------------
    // Move FSM
    // -----------------------------------------------------------------------
    state_t         state;
    state_t         state_next;
    logic [T_W-1:0] t_cnt;
    logic [T_W-1:0] t_cnt_next;
    logic           move_next;
    logic [2:0]     dir_next;

    // State register, timer and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            t_cnt <= '0;
            move  <= 1'b0;
            dir   <= 3'b000;
        end else begin
            state <= state_next;
            t_cnt <= t_cnt_next;
            move  <= move_next;
            dir   <= dir_next;
        end
    end

    // Next state and timer. Every transition clears the timer; the timer
    // idles at zero in IDLE and otherwise never runs past its terminal value
    // because the state always leaves on that value.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (move_press) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (t_cnt == HOLD_LAST) begin
                    state_next = GAP;
                end
            end
            GAP: begin
                if (t_cnt == GAP_LAST) begin
                    state_next = move_held ? REPEAT : IDLE;
                end
            end
            REPEAT: begin
                // Release wins over a repeat that would fire in the same cycle.
                if (!move_held) begin
                    state_next = IDLE;
                end else if (t_cnt == REPEAT_LAST) begin
                    state_next = HOLD;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        t_cnt_next = '0;
        if ((state_next == state) && (state != IDLE)) begin
            t_cnt_next = t_cnt + 1'b1;
        end
    end

    // Outputs. HOLD is only ever entered from IDLE or REPEAT, which are
    // exactly the two points where dir is allowed to take a new value.
    always_comb begin
        move_next = (state_next == HOLD);
        dir_next  = dir;
        if ((state_next == HOLD) && (state != HOLD)) begin
            dir_next = dir_s2;
        end
    end

endmodule
